// File: rtl/pm_min_select_seq.sv
// Sequential best-path-metric selector: scans a captured metric vector LANES
// entries per cycle with modular compares and returns the winning state.
module pm_min_select_seq #(
  parameter int SM_WIDTH   = 8,
  parameter int NUM_STATES = 64,
  parameter int LANES      = 16,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_STATES*SM_WIDTH-1:0] pm_array,
  input  logic                           find_max,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_WIDTH-1:0]           best_index,
  output logic [SM_WIDTH-1:0]            best_value,
  output logic                           busy
);

  localparam int NUM_CHUNKS = NUM_STATES / LANES;
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int LOG_LANES  = $clog2(LANES);
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CHUNK_W-1:0]              chunk_q, chunk_d;
  logic [NUM_STATES*SM_WIDTH-1:0]  vec_q, vec_d;
  logic                            mode_q, mode_d;
  logic [SM_WIDTH-1:0]             acc_val_q, acc_val_d;
  logic [IDX_WIDTH-1:0]            acc_idx_q, acc_idx_d;
  logic [SM_WIDTH-1:0]             best_val_q, best_val_d;
  logic [IDX_WIDTH-1:0]            best_idx_q, best_idx_d;

  logic [SM_WIDTH-1:0]  leaf_val [LANES];
  logic [IDX_WIDTH-1:0] leaf_idx [LANES];
  logic [SM_WIDTH-1:0]  chunk_val, merge_val;
  logic [IDX_WIDTH-1:0] chunk_idx, merge_idx;

  // True when a beats b under modular arithmetic; equal metrics never beat.
  function automatic logic beats(input logic [SM_WIDTH-1:0] a,
                                 input logic [SM_WIDTH-1:0] b,
                                 input logic                max_mode);
    logic [SM_WIDTH-1:0] d;
    d = a - b;
    return max_mode ? (!d[SM_WIDTH-1] && (d != '0)) : d[SM_WIDTH-1];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_leaf
      assign leaf_idx[gi] = IDX_WIDTH'(int'(chunk_q) * LANES + gi);
      assign leaf_val[gi] = vec_q[int'(leaf_idx[gi]) * SM_WIDTH +: SM_WIDTH];
    end
  endgenerate

  // Pairwise reduction in place; slot 2j always holds lower indices than 2j+1.
  always_comb begin
    logic [SM_WIDTH-1:0]  tv [LANES];
    logic [IDX_WIDTH-1:0] ti [LANES];
    for (int i = 0; i < LANES; i++) begin
      tv[i] = leaf_val[i];
      ti[i] = leaf_idx[i];
    end
    for (int l = 1; l <= LOG_LANES; l++) begin
      for (int j = 0; j < (LANES >> l); j++) begin
        if (beats(tv[2*j+1], tv[2*j], mode_q)) begin
          tv[j] = tv[2*j+1];
          ti[j] = ti[2*j+1];
        end else begin
          tv[j] = tv[2*j];
          ti[j] = ti[2*j];
        end
      end
    end
    chunk_val = tv[0];
    chunk_idx = ti[0];
  end

  always_comb begin
    if (chunk_q == '0 || beats(chunk_val, acc_val_q, mode_q)) begin
      merge_val = chunk_val;
      merge_idx = chunk_idx;
    end else begin
      merge_val = acc_val_q;
      merge_idx = acc_idx_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    chunk_d    = chunk_q;
    vec_d      = vec_q;
    mode_d     = mode_q;
    acc_val_d  = acc_val_q;
    acc_idx_d  = acc_idx_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (flush) begin
      state_d = IDLE;
      chunk_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_d   = pm_array;
            mode_d  = find_max;
            chunk_d = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          acc_val_d = merge_val;
          acc_idx_d = merge_idx;
          if (chunk_q == LAST_CHUNK) begin
            best_val_d = merge_val;
            best_idx_d = merge_idx;
            chunk_d    = '0;
            state_d    = DONE;
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      chunk_q    <= '0;
      vec_q      <= '0;
      mode_q     <= 1'b0;
      acc_val_q  <= '0;
      acc_idx_q  <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      chunk_q    <= chunk_d;
      vec_q      <= vec_d;
      mode_q     <= mode_d;
      acc_val_q  <= acc_val_d;
      acc_idx_q  <= acc_idx_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign best_index = best_idx_q;
  assign best_value = best_val_q;

endmodule

// File: tb/tb_pm_min_select_seq.sv
// Directed bench for pm_min_select_seq: hand-computed winners, latency,
// backpressure, flush and asynchronous reset behaviour.
module tb_pm_min_select_seq;
  localparam int SMW = 8;
  localparam int NS  = 64;
  localparam int LN  = 16;
  localparam int IW  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [NS*SMW-1:0] pm_array;
  logic              find_max;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     best_index;
  logic [SMW-1:0]    best_value;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pm_min_select_seq #(.SM_WIDTH(SMW), .NUM_STATES(NS), .LANES(LN), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pm_array(pm_array), .find_max(find_max), .out_valid(out_valid), .out_ready(out_ready),
    .best_index(best_index), .best_value(best_value), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NS*SMW-1:0] fill(input logic [SMW-1:0] val);
    logic [NS*SMW-1:0] v;
    for (int s = 0; s < NS; s++) v[s*SMW +: SMW] = val;
    return v;
  endfunction

  // Accept a vector, scramble inputs during the scan, and check the result.
  task automatic scan(input string tag, input logic [NS*SMW-1:0] v, input logic mode,
                      input int exp_idx, input int exp_val);
    int lat;
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    pm_array = v;
    find_max = mode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    pm_array = '0;
    find_max = ~mode;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'd4);
    check_eq({tag, ".idx"}, 32'(best_index), 32'(exp_idx));
    check_eq({tag, ".val"}, 32'(best_value), 32'(exp_val));
    $display("txn %s: mode=%0d latency=%0d idx=%0d val=0x%0h", tag, mode, lat, best_index, best_value);
  endtask

  task automatic release_result(input string tag, input int exp_idx, input int exp_val);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
    check_eq({tag, ".idx_hold"}, 32'(best_index), 32'(exp_idx));
    check_eq({tag, ".val_hold"}, 32'(best_value), 32'(exp_val));
  endtask

  task automatic run_vec(input string tag, input logic [NS*SMW-1:0] v, input logic mode,
                         input int exp_idx, input int exp_val);
    scan(tag, v, mode, exp_idx, exp_val);
    release_result(tag, exp_idx, exp_val);
  endtask

  initial begin
    logic [NS*SMW-1:0] v;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; pm_array = '0; find_max = 1'b0; out_ready = 1'b0;
    #12;
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.idx", 32'(best_index), 32'd0);
    check_eq("rst.val", 32'(best_value), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);

    for (int s = 0; s < NS; s++) v[s*SMW +: SMW] = SMW'(8'h10 + s);
    run_vec("ramp_min", v, 1'b0, 0, 8'h10);

    v = fill(8'h40); v[5*SMW +: SMW] = 8'hFE; v[40*SMW +: SMW] = 8'h02;
    run_vec("wrap_min", v, 1'b0, 5, 8'hFE);

    v = fill(8'h20); v[10*SMW +: SMW] = 8'h03; v[50*SMW +: SMW] = 8'h03;
    run_vec("tie_xchunk", v, 1'b0, 10, 8'h03);

    v = fill(8'h20); v[17*SMW +: SMW] = 8'h03; v[18*SMW +: SMW] = 8'h03;
    run_vec("tie_inchunk", v, 1'b0, 17, 8'h03);

    for (int s = 0; s < NS - 1; s++) v[s*SMW +: SMW] = SMW'(s);
    v[63*SMW +: SMW] = 8'h7F;
    run_vec("max_top", v, 1'b1, 63, 8'h7F);

    run_vec("max_equal", fill(8'h55), 1'b1, 0, 8'h55);

    v = fill(8'h10); v[20*SMW +: SMW] = 8'h30; v[60*SMW +: SMW] = 8'h30;
    run_vec("max_tie", v, 1'b1, 20, 8'h30);

    // Backpressure: result must hold while the producer keeps pushing.
    v = fill(8'h60); v[33*SMW +: SMW] = 8'h21;
    scan("bp", v, 1'b0, 33, 8'h21);
    for (int c = 0; c < 10; c++) begin
      pm_array = fill(SMW'(c));
      find_max = c[0];
      in_valid = 1'b1;
      tick();
      check_eq("bp.out_valid", 32'(out_valid), 32'd1);
      check_eq("bp.in_ready", 32'(in_ready), 32'd0);
      check_eq("bp.idx", 32'(best_index), 32'd33);
      check_eq("bp.val", 32'(best_value), 32'h21);
    end
    in_valid = 1'b0;
    release_result("bp", 33, 8'h21);

    // Flush in the third scan cycle: no result, previous outputs untouched.
    pm_array = fill(8'h01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("fl.busy", 32'(busy), 32'd1);
    check_eq("fl.in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl.idle", 32'(in_ready), 32'd1);
    check_eq("fl.busy_low", 32'(busy), 32'd0);
    for (int c = 0; c < 6; c++) begin
      check_eq("fl.no_ov", 32'(out_valid), 32'd0);
      tick();
    end
    check_eq("fl.idx_kept", 32'(best_index), 32'd33);
    check_eq("fl.val_kept", 32'(best_value), 32'h21);
    $display("txn flush: busy=%0d out_valid=%0d idx=%0d", busy, out_valid, best_index);

    // Flush wins over an offered vector in IDLE.
    flush = 1'b1;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fliv.busy", 32'(busy), 32'd0);
    check_eq("fliv.in_ready", 32'(in_ready), 32'd1);
    $display("txn flush_with_valid: busy=%0d", busy);

    // Asynchronous reset in mid-scan.
    pm_array = fill(8'h07);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.out_valid", 32'(out_valid), 32'd0);
    check_eq("arst.idx", 32'(best_index), 32'd0);
    check_eq("arst.val", 32'(best_value), 32'd0);
    check_eq("arst.busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("arst.in_ready", 32'(in_ready), 32'd1);
    check_eq("arst.no_ov", 32'(out_valid), 32'd0);
    $display("txn async_reset: out_valid=%0d idx=%0d", out_valid, best_index);

    v = fill(8'h80); v[47*SMW +: SMW] = 8'h7A;
    run_vec("post_rst", v, 1'b0, 47, 8'h7A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
